bcd_counter_ndigit: RTL and testbench
=====================================

Name: bcd_counter_ndigit

Overview:
- Parametrised multi-digit modulo-R up/down counter; successor to the team's single-digit fixed mod-10 counters.
- Each digit counts 0..RADIX-1 and ripples carry/borrow into the next digit within the same edge.
- Supports enable, direction, synchronous parallel load, and a one-period wrap flag.
- Sits behind display drivers and timebase logic as a cascadable event/time counter.

Parameters:
- DIGITS, 4, number of digits; legal 1..8.
- RADIX, 10, modulus per digit; legal 2..16. Each digit is always 4 bits wide.

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- Reset  input  1  asynchronous, active-high reset.
- En  input  1  count enable, sampled at the falling edge.
- Up  input  1  direction: 1 = increment, 0 = decrement.
- Load  input  1  synchronous parallel load, sampled at the falling edge.
- LoadValue  input  4*DIGITS  load data. Digit k is bits [4k+3:4k]; digit 0 is least significant.
- Output  output  4*DIGITS  current count, same digit packing as LoadValue.
- Tc  output  1  combinational terminal count.
- Wrap  output  1  registered wrap flag.

Behaviour:
- Reset asserted: Output=0 and Wrap=0 immediately, held while Reset=1. The first update is the first falling edge after Reset deasserts.
- Priority at each falling edge: Load > En > hold.
- Load=1:
  - Output takes LoadValue.
  - Any load digit >= RADIX is stored as 0 (per digit, independently).
  - Wrap=0.
  - En and Up are ignored.
- En=1, Load=0, Up=1:
  - Digit 0 increments.
  - A digit at RADIX-1 whose carry-in is set goes to 0 and carries into the next digit.
- En=1, Load=0, Up=0:
  - Digit 0 decrements.
  - A digit at 0 whose borrow-in is set goes to RADIX-1 and borrows from the next digit.
- Carry and borrow resolve fully within one edge (no per-digit latency).
- Wrap:
  - Set to 1 for exactly one period after an edge where the top digit carries out (up) or borrows out (down). Counter becomes all-0 (up) or all-(RADIX-1) (down).
  - Otherwise 0 after every edge.
- Tc = En & ~Load & (Up ? all digits == RADIX-1 : all digits == 0). Purely combinational; intended for cascading further instances.
- En=0, Load=0: Output holds; Wrap=0 after the edge.
- Up may change every cycle. Direction reversal takes effect at the next enabled edge.
- A digit that is out of range can only arise by fault. Treat it as RADIX-1 when counting up, so it wraps to 0.
- Reset asserted mid-operation overrides everything asynchronously; no partial update is kept.

Decomposition:
- Shared package holds:
  - DIGIT_W=4.
  - Max-digit and legality constants or functions (digit_max(RADIX), digit_legal).
- One sub-module: bcd_digit, a combinational single-digit next-state.
  - Inputs: cur, cin/bin, up.
  - Outputs: nxt, cout/bout.
- Top level instantiates DIGITS copies in a generate loop, chained on carry, and holds the registers, load clamp, Tc and Wrap.

Test Plan:
1. Default params. Reset pulse, En=1, Up=1, 10 falling edges → Output 0x0000→0x0009→0x0010; Wrap stays 0.
2. Load 0x9998, En=1, Up=1, 2 edges → 0x9999 (Tc=1 before the next edge), then 0x0000 with Wrap=1 for one period. Next edge → 0x0001, Wrap=0.
3. Load 0x0001, Up=0, En=1, 2 edges → 0x0000 (Tc=1), then 0x9999 with Wrap=1.
4. LoadValue 0xA3F5 → Output 0x0305 (illegal digits clamp to 0). Load and En both 1 → load wins, no increment.
5. Count to 0x0042, assert Reset between edges → Output 0x0000 immediately without a clock edge. Hold Reset across 3 edges → stays 0. Release → increments from 0.
6. DIGITS=2, RADIX=6 (minutes/seconds style). Load 0x55, Up=1 → 0x00 with Wrap=1. Up=0 from 0x10 → 0x05. En=0 for 5 edges → Output unchanged.

Source files
------------

// File: rtl/bcd_counter_ndigit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_counter_ndigit_pkg
//  Description : Shared digit width and digit helper functions for the
//                multi-digit modulo-R counter.
//                  DIGIT_W     - bit width of every digit (fixed at 4)
//                  digit_max   - largest legal digit value for a radix
//                  digit_legal - 1 when a digit value is below the radix
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_counter_ndigit_pkg;

    localparam int DIGIT_W = 4;

    function automatic logic [DIGIT_W-1:0] digit_max(input int radix);
        return DIGIT_W'(radix - 1);
    endfunction

    function automatic logic digit_legal(input logic [DIGIT_W-1:0] d, input int radix);
        return int'({28'd0, d}) < radix;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : Combinational next-state of one modulo-RADIX digit.
//  Ports       : cur  - current digit value
//                cin  - carry-in (up) / borrow-in (down); digit moves only
//                       when set
//                up   - 1 = increment, 0 = decrement
//                nxt  - next digit value
//                cout - carry-out (up) / borrow-out (down)
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
    import bcd_counter_ndigit_pkg::*;
#(
    parameter int RADIX = 10
) (
    input  logic [DIGIT_W-1:0] cur,
    input  logic               cin,
    input  logic               up,
    output logic [DIGIT_W-1:0] nxt,
    output logic               cout
);

    localparam logic [DIGIT_W-1:0] c_MAX = digit_max(RADIX);

    always_comb begin
        nxt  = cur;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                // An out-of-range digit behaves like the top value so it
                // recovers to 0 on the next increment.
                if (!digit_legal(cur, RADIX) || (cur == c_MAX)) begin
                    nxt  = '0;
                    cout = 1'b1;
                end else begin
                    nxt = cur + 4'd1;
                end
            end else begin
                if (cur == '0) begin
                    nxt  = c_MAX;
                    cout = 1'b1;
                end else begin
                    nxt = cur - 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_counter_ndigit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_counter_ndigit
//  Description : DIGITS-digit modulo-RADIX up/down counter, updated on the
//                falling edge of clk, with parallel load, terminal count
//                and a one-period wrap flag.
//  Ports       : clk       - clock (state changes on falling edge)
//                Reset     - asynchronous active-high reset
//                En        - count enable
//                Up        - 1 = count up, 0 = count down
//                Load      - parallel load (priority over En)
//                LoadValue - load data, digit k in bits [4k+3:4k]
//                Output    - current count, same packing as LoadValue
//                Tc        - combinational terminal count for cascading
//                Wrap      - high for one period after a top-digit carry or
//                            borrow out
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter_ndigit
    import bcd_counter_ndigit_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int RADIX  = 10
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic                      En,
    input  logic                      Up,
    input  logic                      Load,
    input  logic [DIGIT_W*DIGITS-1:0] LoadValue,
    output logic [DIGIT_W*DIGITS-1:0] Output,
    output logic                      Tc,
    output logic                      Wrap
);

    localparam int                 c_W   = DIGIT_W * DIGITS;
    localparam logic [DIGIT_W-1:0] c_MAX = digit_max(RADIX);

    logic [c_W-1:0]    r_count;
    logic              r_wrap;
    logic [c_W-1:0]    w_next;
    logic [c_W-1:0]    w_load;
    logic [DIGITS:0]   w_carry;
    logic [DIGITS-1:0] w_is_max;
    logic [DIGITS-1:0] w_is_zero;

    // Digit 0 always steps; enable is applied at the register.
    assign w_carry[0] = 1'b1;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            bcd_digit #(
                .RADIX (RADIX)
            ) u_digit (
                .cur  (r_count[DIGIT_W*k +: DIGIT_W]),
                .cin  (w_carry[k]),
                .up   (Up),
                .nxt  (w_next[DIGIT_W*k +: DIGIT_W]),
                .cout (w_carry[k+1])
            );

            // Each illegal load digit is replaced by 0 on its own.
            assign w_load[DIGIT_W*k +: DIGIT_W] =
                digit_legal(LoadValue[DIGIT_W*k +: DIGIT_W], RADIX) ?
                LoadValue[DIGIT_W*k +: DIGIT_W] : '0;

            assign w_is_max[k]  = (r_count[DIGIT_W*k +: DIGIT_W] == c_MAX);
            assign w_is_zero[k] = (r_count[DIGIT_W*k +: DIGIT_W] == '0);
        end
    endgenerate

    assign Tc = En & ~Load & (Up ? (&w_is_max) : (&w_is_zero));

    always_ff @(negedge clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (Load) begin
            r_count <= w_load;
            r_wrap  <= 1'b0;
        end else if (En) begin
            r_count <= w_next;
            r_wrap  <= w_carry[DIGITS];
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    assign Output = r_count;
    assign Wrap   = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_ndigit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_counter_ndigit
//  Description : Self-checking bench for bcd_counter_ndigit. Two instances:
//                A = 4 digits radix 10, B = 2 digits radix 6. The reference
//                model holds each count as a plain integer modulo RADIX**DIGITS.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_counter_ndigit;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_en, a_up, a_ld;
    logic [15:0] a_lv, a_out;
    logic        a_tc, a_wrap;
    logic        b_en, b_up, b_ld;
    logic [7:0]  b_lv, b_out;
    logic        b_tc, b_wrap;

    int   tests = 0;
    int   fails = 0;
    int   ma_cnt, mb_cnt;
    logic ma_wrap, mb_wrap;

    always #5 clk = ~clk;

    bcd_counter_ndigit #(.DIGITS(4), .RADIX(10)) u_a (
        .clk(clk), .Reset(rst), .En(a_en), .Up(a_up), .Load(a_ld),
        .LoadValue(a_lv), .Output(a_out), .Tc(a_tc), .Wrap(a_wrap)
    );

    bcd_counter_ndigit #(.DIGITS(2), .RADIX(6)) u_b (
        .clk(clk), .Reset(rst), .En(b_en), .Up(b_up), .Load(b_ld),
        .LoadValue(b_lv), .Output(b_out), .Tc(b_tc), .Wrap(b_wrap)
    );

    // ---------------- reference model (integer arithmetic) ----------------
    function automatic int pow_i(input int r, input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * r;
        return p;
    endfunction

    function automatic int clamp_val(input logic [15:0] v, input int d, input int r);
        logic [15:0] t = v;
        int n = 0;
        int p = 1;
        for (int k = 0; k < d; k++) begin
            int dg = int'(t[3:0]);
            if (dg >= r) dg = 0;
            n = n + dg * p;
            p = p * r;
            t = t >> 4;
        end
        return n;
    endfunction

    function automatic logic [15:0] to_pk(input int n, input int d, input int r);
        logic [15:0] res = '0;
        int m = n;
        for (int k = 0; k < d; k++) begin
            res = res | (16'(m % r) << (4 * k));
            m = m / r;
        end
        return res;
    endfunction

    function automatic logic tc_model(input int cnt, input int d, input int r,
                                      input logic en, input logic up, input logic ld);
        return en && !ld && (up ? (cnt == pow_i(r, d) - 1) : (cnt == 0));
    endfunction

    task automatic model_edge(input int d, input int r, input logic en, input logic up,
                              input logic ld, input logic [15:0] lv,
                              inout int cnt, output logic wr);
        int m = pow_i(r, d);
        if (ld) begin
            cnt = clamp_val(lv, d, r);
            wr  = 1'b0;
        end else if (en) begin
            if (up) begin
                wr  = (cnt == m - 1);
                cnt = (cnt + 1) % m;
            end else begin
                wr  = (cnt == 0);
                cnt = (cnt + m - 1) % m;
            end
        end else begin
            wr = 1'b0;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_tc();
        chk("a_tc", 16'(a_tc), 16'(tc_model(ma_cnt, 4, 10, a_en, a_up, a_ld)));
        chk("b_tc", 16'(b_tc), 16'(tc_model(mb_cnt, 2, 6, b_en, b_up, b_ld)));
    endtask

    // One falling edge: advance both models, then compare everything.
    task automatic edge_both();
        @(negedge clk);
        if (rst) begin
            ma_cnt = 0; ma_wrap = 1'b0;
            mb_cnt = 0; mb_wrap = 1'b0;
        end else begin
            model_edge(4, 10, a_en, a_up, a_ld, a_lv, ma_cnt, ma_wrap);
            model_edge(2, 6, b_en, b_up, b_ld, {8'h00, b_lv}, mb_cnt, mb_wrap);
        end
        #1;
        chk("a_out",  a_out,           to_pk(ma_cnt, 4, 10));
        chk("a_wrap", 16'(a_wrap),     16'(ma_wrap));
        chk("b_out",  {8'h00, b_out},  to_pk(mb_cnt, 2, 6));
        chk("b_wrap", 16'(b_wrap),     16'(mb_wrap));
    endtask

    typedef struct {
        logic        en;
        logic        up;
        logic        ld;
        logic [15:0] lv;
        logic [15:0] exp_out;
        logic        exp_wrap;
        logic        exp_tc;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 16'h9998, 16'h9998, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h9999, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 16'hA3F5, 16'h0305, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0306, 1'b0, 1'b0};

        a_en = 0; a_up = 0; a_ld = 0; a_lv = '0;
        b_en = 0; b_up = 0; b_ld = 0; b_lv = '0;
        ma_cnt = 0; mb_cnt = 0; ma_wrap = 0; mb_wrap = 0;
        rst = 1'b1;

        // Reset values, before any clock edge.
        #2;
        chk("rst_a_out",  a_out,          16'h0000);
        chk("rst_a_wrap", 16'(a_wrap),    16'h0000);
        chk("rst_b_out",  {8'h00, b_out}, 16'h0000);
        chk("rst_b_wrap", 16'(b_wrap),    16'h0000);
        @(negedge clk); #1;
        rst = 1'b0;

        // Plain up count through a digit rollover.
        a_en = 1; a_up = 1;
        for (int i = 1; i <= 10; i++) begin
            edge_both();
            if (i == 9) chk("t1_nine", a_out, 16'h0009);
        end
        chk("t1_ten",  a_out,       16'h0010);
        chk("t1_wrap", 16'(a_wrap), 16'h0000);

        // Table: wrap up/down, terminal count, load clamp and priority.
        foreach (tbl[i]) begin
            a_en = tbl[i].en; a_up = tbl[i].up; a_ld = tbl[i].ld; a_lv = tbl[i].lv;
            #1;
            chk("tbl_tc", 16'(a_tc), 16'(tbl[i].exp_tc));
            check_tc();
            edge_both();
            chk("tbl_out",  a_out,       tbl[i].exp_out);
            chk("tbl_wrap", 16'(a_wrap), 16'(tbl[i].exp_wrap));
        end

        // Asynchronous reset in the middle of counting.
        a_en = 0; a_ld = 1; a_lv = 16'h0040;
        edge_both();
        a_ld = 0; a_en = 1; a_up = 1;
        edge_both();
        edge_both();
        chk("t5_42", a_out, 16'h0042);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_async_out", a_out, 16'h0000);
        ma_cnt = 0; mb_cnt = 0;
        repeat (3) edge_both();
        rst = 1'b0;
        edge_both();
        chk("t5_after", a_out, 16'h0001);

        // Instance B: radix 6, two digits.
        a_en = 0;
        b_ld = 1; b_lv = 8'h55;
        edge_both();
        b_ld = 0; b_en = 1; b_up = 1;
        #1;
        chk("t6_tc", 16'(b_tc), 16'h0001);
        edge_both();
        chk("t6_wrap_out", {8'h00, b_out}, 16'h0000);
        chk("t6_wrap",     16'(b_wrap),    16'h0001);
        b_ld = 1; b_lv = 8'h10;
        edge_both();
        b_ld = 0; b_up = 0;
        edge_both();
        chk("t6_down", {8'h00, b_out}, 16'h0005);
        b_en = 0;
        repeat (5) edge_both();
        chk("t6_hold", {8'h00, b_out}, 16'h0005);

        // Randomized traffic on both instances against the model.
        for (int i = 0; i < 400; i++) begin
            a_en = ($urandom_range(0, 9) < 8);
            a_up = 1'($urandom_range(0, 1));
            a_ld = ($urandom_range(0, 19) == 0);
            a_lv = 16'($urandom);
            b_en = ($urandom_range(0, 9) < 8);
            b_up = 1'($urandom_range(0, 1));
            b_ld = ($urandom_range(0, 19) == 0);
            b_lv = 8'($urandom);
            #1;
            check_tc();
            edge_both();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
